bram_port_ctrl: RTL

Request/response controller that owns one port of a true-dual-port byte-write BRAM wrapper (9-bit address, 64-bit data, 8 byte-enables, 1-cycle registered read). Converts a valid/ready request stream (single or burst reads, burst fills) into cycle-exact BRAM port EN/WE/ADDR/DI activity. Captures read data into a 2-entry response buffer so consumers can apply backpressure without losing data. Intended as the engine-side initiator for the BRAM port not driven by the host.

---
 rtl/bram_port_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl: engine-side initiator for one port of a byte-write BRAM.
// Turns a valid/ready request stream (single/burst reads, burst fills) into
// per-cycle BRAM EN/WE/ADDR/DI activity and buffers read data in a 2-entry
// response FIFO so the consumer may stall without data loss.
// Optional feature macro: BRAM_CTRL_WRACK_EN (fill bursts return one ack).
//
// state | meaning
// IDLE  | waiting for a request; req_ready high, BRAM port quiet
// BURST | issuing one beat per permitted cycle until beat_cnt == len
module bram_port_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [DATA_W-1:0]   req_data,
   input  logic [DATA_W/8-1:0] req_strb,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_data,
   output logic                resp_last,
   output logic                resp_wr,
   output logic                bram_EN,
   output logic [DATA_W/8-1:0] bram_WE,
   output logic [ADDR_W-1:0]   bram_ADDR,
   output logic [DATA_W-1:0]   bram_DI,
   input  logic [DATA_W-1:0]   bram_DO
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   data_q;
   logic [STRB_W-1:0]   strb_q;

   logic                infl_q;
   logic                infl_last_q;

   logic [DATA_W-1:0]   fifo_data [2];
   logic                fifo_last [2];
   logic                rd_ptr, wr_ptr;
   logic [1:0]          count;

   logic                accept;
   logic                pop;
   logic                push;
   logic                credit_ok;
   logic                final_beat;
   logic                ack_beat;
   logic                beat;
   logic                issue;
   logic [DATA_W-1:0]   push_data;

   assign req_ready  = (state_q == IDLE) && !reset;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (count != 2'd0);
   assign pop        = resp_valid && resp_ready;
   assign push       = infl_q;
   assign final_beat = (cnt_q == len_q);

   // A response slot is free if what is buffered plus what is in flight,
   // minus what leaves this cycle, stays below the FIFO depth.
   assign credit_ok  = (({1'b0, count} + {2'b00, infl_q}) - {2'b00, pop}) < 3'd2;

`ifdef BRAM_CTRL_WRACK_EN
   logic                infl_wr_q;
   logic                fifo_wr [2];

   assign ack_beat   = wr_q && final_beat;
   assign push_data  = infl_wr_q ? '0 : bram_DO;
   assign resp_wr    = resp_valid ? fifo_wr[rd_ptr] : 1'b0;
`else
   assign ack_beat   = 1'b0;
   assign push_data  = bram_DO;
   assign resp_wr    = 1'b0;
`endif

   // Fill beats bypass the credit check unless they produce a response.
   assign beat  = (state_q == BURST) && ((wr_q && !ack_beat) || credit_ok);
   assign issue = beat && (!wr_q || ack_beat);

   assign resp_data = resp_valid ? fifo_data[rd_ptr] : '0;
   assign resp_last = resp_valid ? fifo_last[rd_ptr] : 1'b0;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and BRAM port drive; port is all-zero on non-beat cycles.
   always_comb begin
      state_d   = state_q;
      bram_EN   = 1'b0;
      bram_WE   = '0;
      bram_ADDR = '0;
      bram_DI   = '0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = BURST;
         end
         BURST: begin
            if (beat) begin
               bram_EN   = 1'b1;
               bram_ADDR = addr_q;
               bram_WE   = wr_q ? strb_q : '0;
               bram_DI   = wr_q ? data_q : '0;
               if (final_beat) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, running address (wraps at 2^ADDR_W) and beat counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q   <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         strb_q <= '0;
      end else if (accept) begin
         wr_q   <= req_wr;
         addr_q <= req_addr;
         len_q  <= req_len;
         cnt_q  <= '0;
         data_q <= req_data;
         strb_q <= req_strb;
      end else if (beat) begin
         addr_q <= addr_q + ADDR_W'(1);
         cnt_q  <= cnt_q + LEN_W'(1);
      end
   end

   // Track the beat whose result lands in the FIFO next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         infl_q      <= issue;
         infl_last_q <= final_beat;
      end
   end

`ifdef BRAM_CTRL_WRACK_EN
   // Remember whether the in-flight entry is a write ack.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         infl_wr_q  <= 1'b0;
         fifo_wr[0] <= 1'b0;
         fifo_wr[1] <= 1'b0;
      end else begin
         infl_wr_q <= wr_q;
         if (push) fifo_wr[wr_ptr] <= infl_wr_q;
      end
   end
`endif

   // Two-entry response FIFO; push and pop may coincide at any occupancy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         count        <= 2'd0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_last[wr_ptr] <= infl_last_q;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= (count + {1'b0, push}) - {1'b0, pop};
      end
   end

   // The credit rule must make overflow unreachable.
   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && (count == 2'd2)));

endmodule
